// File: rtl/dcache_flush_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_flush_ctrl
//
// Miss handler for a direct-mapped data cache line. When the CPU touches a
// line that misses, the controller takes ownership of the line. If the
// resident line is dirty, it first writes every word back to memory. It then
// refills the line word by word from memory at the new tag. The CPU is
// stalled for the whole transfer.
//
// Parameters
//   DATABITS       data word width
//   ADDRBITS       byte address width
//   CACHEADDRBITS  log2 of words per line
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   req_addr/req_valid    pending CPU access (sampled only in IDLE)
//   line_miss/line_dirty  status of the addressed line
//   line_memory_section   base byte address of the resident (victim) line
//   line_data             line word at flush_addr, one cycle later
//   flush_mode            controller owns the line
//   flush_we/flush_addr/flush_in   line write port used during refill
//   stall                 CPU access must be held
//   mem_addr/mem_rdreq/mem_wrreq/mem_wrdata/mem_ready   memory request
//   mem_rddata/mem_rddata_valid                         memory read return
// ---------------------------------------------------------------------------
module dcache_flush_ctrl #(
  parameter int DATABITS      = 32,
  parameter int ADDRBITS      = 32,
  parameter int CACHEADDRBITS = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDRBITS-1:0] req_addr,
  input  logic                req_valid,
  input  logic                line_miss,
  input  logic                line_dirty,
  input  logic [ADDRBITS-1:0] line_memory_section,
  input  logic [DATABITS-1:0] line_data,
  output logic                flush_mode,
  output logic                flush_we,
  output logic [ADDRBITS-1:0] flush_addr,
  output logic [DATABITS-1:0] flush_in,
  output logic                stall,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic                mem_rdreq,
  output logic                mem_wrreq,
  output logic [DATABITS-1:0] mem_wrdata,
  input  logic                mem_ready,
  input  logic [DATABITS-1:0] mem_rddata,
  input  logic                mem_rddata_valid
);

  localparam int TAGBITS = ADDRBITS - CACHEADDRBITS - 2;
  localparam logic [CACHEADDRBITS-1:0] CNT_LAST = '1;

  typedef enum logic [2:0] {
    IDLE,
    WB_RD,
    WB_WR,
    FILL_REQ,
    FILL_WAIT,
    DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CACHEADDRBITS-1:0] cnt_q, cnt_d;
  logic [TAGBITS-1:0]       tag_q, tag_d;
  logic [ADDRBITS-1:0]      victim_q, victim_d;
  logic [DATABITS-1:0]      wrData_q, wrData_d;
  logic                     wrHeld_q, wrHeld_d;

  logic [ADDRBITS-1:0] victimWordAddr;
  logic [ADDRBITS-1:0] fillWordAddr;
  logic [DATABITS-1:0] wbData;
  logic                missReq;
  logic                unusedReqBits;

  // Byte offset and word index of the CPU address do not take part in the tag.
  assign unusedReqBits  = ^req_addr[CACHEADDRBITS+1:0];

  assign victimWordAddr = victim_q + {{TAGBITS{1'b0}}, cnt_q, 2'b00};
  assign fillWordAddr   = {tag_q, cnt_q, 2'b00};
  assign missReq        = req_valid & line_miss;

  // line_data for the word addressed in WB_RD only becomes valid during the
  // first WB_WR cycle, so that cycle passes it straight through and captures
  // it; later WB_WR cycles replay the captured copy so memory sees a stable
  // word while it applies backpressure.
  assign wbData = wrHeld_q ? wrData_q : line_data;

  assign flush_mode = (state_q != IDLE);
  assign stall      = flush_mode | missReq;

  // State and datapath registers; reset drops everything immediately, which
  // also aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tag_q    <= '0;
      victim_q <= '0;
      wrData_q <= '0;
      wrHeld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      victim_q <= victim_d;
      wrData_q <= wrData_d;
      wrHeld_q <= wrHeld_d;
    end
  end

  // Next-state and output decode. All outputs are zero unless the current
  // state drives them, so IDLE (and therefore reset) presents a quiet bus.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    victim_d   = victim_q;
    wrData_d   = wrData_q;
    wrHeld_d   = 1'b0;
    flush_we   = 1'b0;
    flush_addr = '0;
    flush_in   = '0;
    mem_addr   = '0;
    mem_rdreq  = 1'b0;
    mem_wrreq  = 1'b0;
    mem_wrdata = '0;

    unique case (state_q)
      IDLE: begin
        if (missReq) begin
          tag_d    = req_addr[ADDRBITS-1:CACHEADDRBITS+2];
          victim_d = line_memory_section;
          cnt_d    = '0;
          state_d  = line_dirty ? WB_RD : FILL_REQ;
        end
      end

      WB_RD: begin
        flush_addr = victimWordAddr;
        state_d    = WB_WR;
      end

      WB_WR: begin
        mem_addr   = victimWordAddr;
        mem_wrreq  = 1'b1;
        mem_wrdata = wbData;
        wrData_d   = wbData;
        wrHeld_d   = 1'b1;
        if (mem_ready) begin
          wrHeld_d = 1'b0;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = FILL_REQ;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = WB_RD;
          end
        end
      end

      FILL_REQ: begin
        mem_addr  = fillWordAddr;
        mem_rdreq = 1'b1;
        if (mem_ready) begin
          state_d = FILL_WAIT;
        end
      end

      FILL_WAIT: begin
        if (mem_rddata_valid) begin
          flush_we   = 1'b1;
          flush_in   = mem_rddata;
          flush_addr = fillWordAddr;
          cnt_d      = cnt_q + 1'b1;
          state_d    = (cnt_q == CNT_LAST) ? DONE : FILL_REQ;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/dcache_flush_ctrl.md
DCACHE_FLUSH_CTRL -- requirements
Module: dcache_flush_ctrl

Interface
REQ-001 Parameter DATABITS, default 32, SHALL set the data word width.
REQ-002 Parameter ADDRBITS, default 32, SHALL set the byte address width.
REQ-003 Parameter CACHEADDRBITS, default 5, SHALL set words per line as 2**CACHEADDRBITS.
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_addr  in  ADDRBITS  CPU byte address of the pending access.
- req_valid  in  1  CPU read or write request pending.
- line_miss  in  1  cache line reports tag miss or uninitialised.
- line_dirty  in  1  cache line holds modified data.
- line_memory_section  in  ADDRBITS  base byte address of the resident line.
- line_data  in  DATABITS  line word read at flush_addr, valid 1 cycle after flush_addr is presented.
- flush_mode  out  1  line is under controller ownership.
- flush_we  out  1  write flush_in into the line at flush_addr.
- flush_addr  out  ADDRBITS  byte address for line access during flush.
- flush_in  out  DATABITS  fill data to the line.
- stall  out  1  CPU access must be held.
- mem_addr  out  ADDRBITS  memory byte address.
- mem_rdreq  out  1  memory read request, held until mem_ready.
- mem_wrreq  out  1  memory write request, held until mem_ready.
- mem_wrdata  out  DATABITS  write data, stable while mem_wrreq=1.
- mem_ready  in  1  memory accepts the current request this cycle.
- mem_rddata  in  DATABITS  read return data.
- mem_rddata_valid  in  1  mem_rddata is valid this cycle; in-order, one outstanding read.

Function
REQ-005 The FSM SHALL have states IDLE, WB_RD, WB_WR, FILL_REQ, FILL_WAIT and DONE.
REQ-006 In IDLE with req_valid=1 and line_miss=1, the block SHALL capture tag = req_addr[ADDRBITS-1:CACHEADDRBITS+2] and victim = line_memory_section, clear the word counter, and go to WB_RD if line_dirty=1, else to FILL_REQ.
REQ-007 flush_mode SHALL be 1 in every state except IDLE.
REQ-008 stall SHALL equal flush_mode OR (req_valid AND line_miss), combinationally.
REQ-009 In WB_RD, flush_addr SHALL be victim + 4*cnt; the FSM SHALL go to WB_WR after exactly 1 cycle.
REQ-010 On entry to WB_WR, line_data SHALL be registered into mem_wrdata; mem_addr SHALL be victim + 4*cnt and mem_wrreq SHALL be 1.
REQ-011 In WB_WR, mem_wrreq SHALL stay 1 with stable address and data until mem_ready=1.
REQ-012 On WB_WR with mem_ready=1, cnt SHALL increment; the FSM SHALL go to WB_RD, or to FILL_REQ with cnt cleared if cnt was 2**CACHEADDRBITS-1.
REQ-013 In FILL_REQ, mem_addr SHALL be {tag, cnt, 2'b00} and mem_rdreq SHALL be 1 until mem_ready=1; then the FSM SHALL go to FILL_WAIT.
REQ-014 In FILL_WAIT, on mem_rddata_valid=1, flush_we SHALL pulse 1 cycle with flush_in = mem_rddata and flush_addr = {tag, cnt, 2'b00}, and cnt SHALL increment.
REQ-015 After that write, the FSM SHALL go to FILL_REQ, or to DONE if cnt was 2**CACHEADDRBITS-1.
REQ-016 DONE SHALL last 1 cycle, then the FSM SHALL return to IDLE; line_miss is re-evaluated only in IDLE.
REQ-017 mem_rdreq and mem_wrreq SHALL never be 1 in the same cycle.
REQ-018 flush_we SHALL be 0 outside FILL_WAIT.
REQ-019 cnt SHALL be CACHEADDRBITS wide and wrap to 0 after its last increment.
REQ-020 mem_rddata_valid outside FILL_WAIT SHALL be ignored.
REQ-021 req_valid and req_addr changes while not in IDLE SHALL be ignored; the captured tag is used.

Reset
REQ-022 When reset_n=0, the block SHALL asynchronously set state=IDLE, cnt=0, and tag, victim and mem_wrdata to 0.
REQ-023 During reset, flush_mode, flush_we, mem_rdreq and mem_wrreq SHALL be 0, and flush_addr, flush_in and mem_addr SHALL be 0.
REQ-024 Reset asserted mid-transfer SHALL abort immediately, with no further memory request or line write.

Verification
REQ-025 Clean miss: line_dirty=0, req_addr=0x0000_1084, mem_ready=1, data valid 2 cycles later -> 32 reads at 0x1080..0x10FC; 32 flush_we pulses, where word n carries read n; stall drops the cycle after DONE.
REQ-026 Dirty miss: line_memory_section=0x0000_2000, line_dirty=1, req_addr=0x0000_3000 -> 32 writes to 0x2000..0x207C carrying line_data words in order, then 32 reads at 0x3000..0x307C.
REQ-027 Backpressure: mem_ready=0 for 5 cycles per request -> mem_wrreq/mem_rdreq held with stable mem_addr and mem_wrdata; no word skipped or duplicated.
REQ-028 Stray data: mem_rddata_valid=1 in IDLE and in WB_WR -> no flush_we pulse and cnt unchanged.
REQ-029 Reset mid-fill: reset_n=0 at word 10 of the fill -> all outputs 0 in the same cycle; after release with line_miss=1 and req_valid=1, a full fill restarts from word 0.
REQ-030 Hit: req_valid=1, line_miss=0 -> flush_mode=0, stall=0, no memory request for 100 cycles.
